// File: rtl/seg7_scan_animator.sv
// seg7_scan_animator: 8-digit multiplexed 7-segment driver.
// Holds a 16-entry character buffer, scans one digit per dwell period and
// steps a scroll offset on a slower animation tick.
// Optional blink animation for mode 2'b10 is built when SEG7_BLINK_EN is defined.
module seg7_scan_animator #(
    parameter int SCAN_DIV = 100000,
    parameter int STEP_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [1:0] mode,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [4:0] wr_data,
    output logic [6:0] segmentos,
    output logic [7:0] anodos,
    output logic       step_pulse
);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int STEP_W = $clog2(STEP_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t            state_q;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [2:0]        dig_q, dig_d;
    logic [3:0]        off_q, off_d;
    logic [4:0]        msg_q [16];
    logic [7:0]        an_q;
    logic [6:0]        seg_q;
    logic              pulse_q;
    logic              scan_tc, step_tc, blank_w;
    logic [3:0]        rd_idx;
`ifdef SEG7_BLINK_EN
    logic              phase_q, phase_d;
`endif

    // Active-low segment patterns, bit 6 = a .. bit 0 = g.
    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        case (code)
            5'h00: seg_decode = 7'b0000001;
            5'h01: seg_decode = 7'b1001111;
            5'h02: seg_decode = 7'b0010010;
            5'h03: seg_decode = 7'b0000110;
            5'h04: seg_decode = 7'b1001100;
            5'h05: seg_decode = 7'b0100100;
            5'h06: seg_decode = 7'b0100000;
            5'h07: seg_decode = 7'b0001111;
            5'h08: seg_decode = 7'b0000000;
            5'h09: seg_decode = 7'b0000100;
            5'h0A: seg_decode = 7'b0001000;
            5'h0B: seg_decode = 7'b1100000;
            5'h0C: seg_decode = 7'b0110001;
            5'h0D: seg_decode = 7'b1000010;
            5'h0E: seg_decode = 7'b0110000;
            5'h0F: seg_decode = 7'b0111000;
            5'h11: seg_decode = 7'b1111110;
            5'h12: seg_decode = 7'b1001000;
            5'h13: seg_decode = 7'b1110001;
            5'h14: seg_decode = 7'b0011000;
            5'h15: seg_decode = 7'b1000001;
            default: seg_decode = 7'h7F;
        endcase
    endfunction

    // Next-state values for the scan/step counters, digit index and offset.
    always_comb begin
        scan_tc = (scan_q == SCAN_LAST);
        step_tc = (step_q == STEP_LAST);
        scan_d  = scan_tc ? '0 : scan_q + SCAN_W'(1);
        step_d  = step_tc ? '0 : step_q + STEP_W'(1);
        dig_d   = scan_tc ? dig_q + 3'd1 : dig_q;
        off_d   = (step_tc && mode == 2'b01) ? off_q + 4'd1 : off_q;
        rd_idx  = off_q + {1'b0, dig_q};
`ifdef SEG7_BLINK_EN
        // Leaving blink mode clears the phase at the next step tick.
        phase_d = step_tc ? ((mode == 2'b10) ? ~phase_q : 1'b0) : phase_q;
        blank_w = phase_q;
`else
        blank_w = 1'b0;
`endif
    end

    // Message buffer: writes are accepted in any state, reset fills with blanks.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) msg_q[i] <= 5'h10;
        end else if (wr_en) begin
            msg_q[wr_addr] <= wr_data;
        end
    end

    // IDLE/RUN controller with registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            scan_q  <= '0;
            step_q  <= '0;
            dig_q   <= '0;
            off_q   <= '0;
            an_q    <= 8'hFF;
            seg_q   <= 7'h7F;
            pulse_q <= 1'b0;
`ifdef SEG7_BLINK_EN
            phase_q <= 1'b0;
`endif
        end else if (state_q == S_IDLE || !run) begin
            // Blanked: counters parked at zero so re-entry starts on AN0; offset kept.
            state_q <= run ? S_RUN : S_IDLE;
            scan_q  <= '0;
            step_q  <= '0;
            dig_q   <= '0;
            an_q    <= 8'hFF;
            seg_q   <= 7'h7F;
            pulse_q <= 1'b0;
`ifdef SEG7_BLINK_EN
            phase_q <= 1'b0;
`endif
        end else begin
            scan_q  <= scan_d;
            step_q  <= step_d;
            dig_q   <= dig_d;
            off_q   <= off_d;
            pulse_q <= step_tc;
            an_q    <= blank_w ? 8'hFF : ~(8'd1 << dig_q);
            seg_q   <= blank_w ? 7'h7F : seg_decode(msg_q[rd_idx]);
`ifdef SEG7_BLINK_EN
            phase_q <= phase_d;
`endif
        end
    end

    assign segmentos  = seg_q;
    assign anodos     = an_q;
    assign step_pulse = pulse_q;

endmodule

// File: tb/tb_seg7_scan_animator.sv
// Testbench for seg7_scan_animator with SCAN_DIV=4, STEP_DIV=16.
module tb_seg7_scan_animator;
    localparam int SCAN_DIV = 4;
    localparam int STEP_DIV = 16;

    logic       clk = 1'b0;
    logic       rst, run, wr_en;
    logic [1:0] mode;
    logic [3:0] wr_addr;
    logic [4:0] wr_data;
    logic [6:0] segmentos;
    logic [7:0] anodos;
    logic       step_pulse;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [4:0] code;
        logic [6:0] seg;
    } vec_t;
    vec_t tbl [32];
    logic [6:0] exp_q [$];

    always #5 clk = ~clk;

    seg7_scan_animator #(.SCAN_DIV(SCAN_DIV), .STEP_DIV(STEP_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .mode       (mode),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .segmentos  (segmentos),
        .anodos     (anodos),
        .step_pulse (step_pulse)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic write_buf(input logic [3:0] a, input logic [4:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Expected anode pattern at RUN edge k (4 cycles per digit).
    function automatic logic [7:0] an_exp(input int k);
        logic [7:0] one;
        one = 8'd1;
        return ~(one << ((k / 4) % 8));
    endfunction

    function automatic logic [3:0] dig_of(input int k);
        return 4'((k / 4) % 8);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] off_m;
        logic [3:0] idx;
        logic       found;
        logic       blank;

        tbl[5'h00] = '{5'h00, 7'b0000001};
        tbl[5'h01] = '{5'h01, 7'b1001111};
        tbl[5'h02] = '{5'h02, 7'b0010010};
        tbl[5'h03] = '{5'h03, 7'b0000110};
        tbl[5'h04] = '{5'h04, 7'b1001100};
        tbl[5'h05] = '{5'h05, 7'b0100100};
        tbl[5'h06] = '{5'h06, 7'b0100000};
        tbl[5'h07] = '{5'h07, 7'b0001111};
        tbl[5'h08] = '{5'h08, 7'b0000000};
        tbl[5'h09] = '{5'h09, 7'b0000100};
        tbl[5'h0A] = '{5'h0A, 7'b0001000};
        tbl[5'h0B] = '{5'h0B, 7'b1100000};
        tbl[5'h0C] = '{5'h0C, 7'b0110001};
        tbl[5'h0D] = '{5'h0D, 7'b1000010};
        tbl[5'h0E] = '{5'h0E, 7'b0110000};
        tbl[5'h0F] = '{5'h0F, 7'b0111000};
        tbl[5'h10] = '{5'h10, 7'h7F};
        tbl[5'h11] = '{5'h11, 7'b1111110};
        tbl[5'h12] = '{5'h12, 7'b1001000};
        tbl[5'h13] = '{5'h13, 7'b1110001};
        tbl[5'h14] = '{5'h14, 7'b0011000};
        tbl[5'h15] = '{5'h15, 7'b1000001};
        for (int i = 16'h16; i < 32; i++) tbl[i] = '{5'(i), 7'h7F};

        // Reset, with a write attempted during reset.
        rst = 1'b1; run = 1'b0; mode = 2'b00;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        tick();
        tick();
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 5'h05;
        tick();
        rst = 1'b0; wr_en = 1'b0;
        chk("rst_anodos", 32'(anodos), 32'hFF);
        chk("rst_seg", 32'(segmentos), 32'h7F);
        chk("rst_pulse", 32'(step_pulse), 32'h0);
        run = 1'b1;
        tick();
        chk("entry_blank", 32'(anodos), 32'hFF);
        tick();
        chk("rstwr_an", 32'(anodos), 32'hFE);
        chk("rstwr_seg", 32'(segmentos), 32'h7F);
        run = 1'b0;
        tick();
        chk("stop_an", 32'(anodos), 32'hFF);
        chk("stop_seg", 32'(segmentos), 32'h7F);

        // First display and full scan sequence.
        write_buf(4'd0, 5'h0A);
        run = 1'b1;
        tick();
        chk("start_blank", 32'(anodos), 32'hFF);
        for (int k = 0; k < 40; k++) begin
            tick();
            chk("scan_an", 32'(anodos), 32'(an_exp(k)));
            chk("scan_onehot", 32'($countones(~anodos)), 32'd1);
            chk("scan_seg", 32'(segmentos), (dig_of(k) == 4'd0) ? 32'b0001000 : 32'h7F);
            chk("scan_pulse", 32'(step_pulse), 32'((k % 16) == 15));
        end

        // run dropped mid-dwell, re-entry from AN0, then one-cycle write latency.
        tick();
        run = 1'b0;
        tick();
        chk("drop_an", 32'(anodos), 32'hFF);
        chk("drop_seg", 32'(segmentos), 32'h7F);
        chk("drop_pulse", 32'(step_pulse), 32'h0);
        tick();
        chk("idle_an", 32'(anodos), 32'hFF);
        run = 1'b1;
        tick();
        chk("reent_blank", 32'(anodos), 32'hFF);
        tick();
        chk("reent_an", 32'(anodos), 32'hFE);
        chk("reent_seg", 32'(segmentos), 32'b0001000);
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 5'h12;
        tick();
        wr_en = 1'b0;
        chk("wr_old_seg", 32'(segmentos), 32'b0001000);
        tick();
        chk("wr_new_seg", 32'(segmentos), 32'b1001000);
        chk("wr_new_an", 32'(anodos), 32'hFE);

        // Decode table through the scoreboard.
        run = 1'b0;
        tick();
        for (int i = 0; i < 32; i++) begin
            for (int a = 0; a < 16; a++) write_buf(4'(a), tbl[i].code);
            run = 1'b1;
            exp_q.push_back(tbl[i].seg);
            found = 1'b0;
            for (int w = 0; w < 6 && !found; w++) begin
                tick();
                if (anodos != 8'hFF) found = 1'b1;
            end
            if (found) begin
                chk("dec_an", 32'(anodos), 32'hFE);
                chk("dec_seg", 32'(segmentos), 32'(exp_q.pop_front()));
            end else begin
                chk("dec_timeout", 32'(anodos), 32'hFE);
                void'(exp_q.pop_front());
            end
            run = 1'b0;
            tick();
        end

        // Scroll with a mid-run mode change; offset wraps past 15.
        for (int a = 0; a < 16; a++) write_buf(4'(a), 5'(a));
        mode = 2'b01;
        run = 1'b1;
        tick();
        off_m = 4'd0;
        for (int k = 0; k < 400; k++) begin
            mode = (k >= 100 && k < 160) ? 2'b00 : 2'b01;
            tick();
            idx = off_m + dig_of(k);
            chk("scr_an", 32'(anodos), 32'(an_exp(k)));
            chk("scr_seg", 32'(segmentos), 32'(tbl[idx].seg));
            chk("scr_pulse", 32'(step_pulse), 32'((k % 16) == 15));
            if ((k % 16) == 15 && mode == 2'b01) off_m = off_m + 4'd1;
        end
        run = 1'b0;
        tick();
        chk("scr_drop_an", 32'(anodos), 32'hFF);
        chk("scr_drop_seg", 32'(segmentos), 32'h7F);
        run = 1'b1;
        tick();
        tick();
        chk("scr_reent_an", 32'(anodos), 32'hFE);
        chk("scr_off_kept", 32'(segmentos), 32'(tbl[off_m].seg));

        // Mode 10: blinks only when the blink feature is built in.
        run = 1'b0;
        mode = 2'b10;
        tick();
        run = 1'b1;
        tick();
        for (int k = 0; k < 64; k++) begin
            tick();
`ifdef SEG7_BLINK_EN
            blank = ((k / 16) % 2) == 1;
`else
            blank = 1'b0;
`endif
            idx = off_m + dig_of(k);
            chk("blink_an", 32'(anodos), blank ? 32'hFF : 32'(an_exp(k)));
            chk("blink_seg", 32'(segmentos), blank ? 32'h7F : 32'(tbl[idx].seg));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
